chime_selector: RTL and testbench

- Parametrised successor to the two-input doorbell chime multiplexer.
- Selects one of N_CH sound sample streams of WIDTH bits each.
- Delays the chosen stream by a fixed, parametrised number of clock cycles.
- Mutes for a programmable interval on every channel change so there is no audible click.
- Sits between the sound-sample sources and the chime output driver.

---
 rtl/chime_selector_pkg.sv | 18 +
 rtl/chime_selector_if.sv | 28 ++
 rtl/chime_selector_delay_line.sv | 24 ++
 rtl/chime_selector.sv | 105 ++++++++++
 tb/tb_chime_selector.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/chime_selector_pkg.sv
// Shared types and defaults for the chime selector: FSM state encoding,
// select-width helper and default sample geometry.
package chime_pkg;

   typedef enum logic {
      PLAY = 1'b0,
      MUTE = 1'b1
   } state_t;

   localparam int CHIME_WIDTH = 24;
   localparam int CHIME_DELAY = 5;

   // A two-channel selector still needs a one-bit select.
   function automatic int sel_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chime_selector_if.sv
// Sample-source / chime-driver bundle for chime_selector.
// master = the side feeding samples and selections, slave = the selector.
interface chime_selector_if
   import chime_pkg::*;
#(
   parameter int WIDTH = CHIME_WIDTH,
   parameter int N_CH  = 4
) ();
   localparam int SEL_W = sel_w(N_CH);

   logic [N_CH*WIDTH-1:0] ch_data;
   logic [SEL_W-1:0]      sel;
   logic                  sel_valid;
   logic [WIDTH-1:0]      out;
   logic                  out_valid;
   logic                  busy;
   logic                  sel_err;

   modport master (
      output ch_data, sel, sel_valid,
      input  out, out_valid, busy, sel_err
   );

   modport slave (
      input  ch_data, sel, sel_valid,
      output out, out_valid, busy, sel_err
   );
endinterface

// File: rtl/chime_selector_delay_line.sv
// Fixed-latency shift register: q is d delayed by DELAY clocks, no stall input.
// Synchronous active-low reset clears every stage.
module chime_delay_line #(
   parameter int WIDTH = 25,
   parameter int DELAY = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] pipe [DELAY];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DELAY-1];
endmodule

// File: rtl/chime_selector.sv
// N_CH-way chime sample selector, DELAY-cycle latency, muting MUTE_CYCLES on each change;
// no backpressure. CHIME_SEL_HOLD_EN: hold the last played sample while muted instead of silence.
module chime_selector
   import chime_pkg::*;
#(
   parameter int WIDTH       = CHIME_WIDTH,
   parameter int N_CH        = 4,
   parameter int DELAY       = CHIME_DELAY,
   parameter int MUTE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   chime_selector_if.slave  bus
);
   localparam int             SEL_W   = sel_w(N_CH);
   localparam logic [SEL_W:0] N_CH_L  = (SEL_W+1)'(N_CH);
   localparam logic [7:0]     MUTE_LD = 8'(MUTE_CYCLES - 1);

   state_t           state;
   logic [SEL_W-1:0] cur_sel;
   logic [SEL_W-1:0] pending;
   logic [7:0]       cnt;
   logic             busy_r;
   logic             sel_err_r;

   logic [WIDTH-1:0] ch [N_CH];
   logic [WIDTH-1:0] mute_val;
   logic [WIDTH-1:0] stage0;
   logic             sel_legal;
   logic [WIDTH:0]   dl_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign ch[k] = bus.ch_data[k*WIDTH +: WIDTH];
   end

   assign sel_legal = {1'b0, bus.sel} < N_CH_L;

`ifdef CHIME_SEL_HOLD_EN
   logic [WIDTH-1:0] hold;

   // Captured every PLAY cycle, so it freezes on the value taken the cycle the mute starts.
   always_ff @(posedge clk) begin
      if (!rst_n)              hold <= '0;
      else if (state == PLAY)  hold <= stage0;
   end
   assign mute_val = hold;
`else
   assign mute_val = '0;
`endif

   assign stage0 = (state == MUTE) ? mute_val : ch[cur_sel];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= PLAY;
         cur_sel   <= '0;
         pending   <= '0;
         cnt       <= '0;
         busy_r    <= 1'b0;
         sel_err_r <= 1'b0;
      end else begin
         if (bus.sel_valid && !sel_legal) sel_err_r <= 1'b1;
         case (state)
            PLAY: begin
               if (bus.sel_valid && sel_legal && bus.sel != cur_sel) begin
                  pending <= bus.sel;
                  cnt     <= MUTE_LD;
                  busy_r  <= 1'b1;
                  state   <= MUTE;
               end
            end
            MUTE: begin
               // A legal request restarts the mute, even on its final cycle.
               if (bus.sel_valid && sel_legal) begin
                  pending <= bus.sel;
                  cnt     <= MUTE_LD;
               end else if (cnt == 8'd0) begin
                  cur_sel <= pending;
                  busy_r  <= 1'b0;
                  state   <= PLAY;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= PLAY;
         endcase
      end
   end

   // The valid bit rides with the sample; reset flushes it, so a constant 1 suffices.
   chime_delay_line #(
      .WIDTH (WIDTH + 1),
      .DELAY (DELAY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({1'b1, stage0}),
      .q     (dl_q)
   );

   assign bus.out       = dl_q[WIDTH-1:0];
   assign bus.out_valid = dl_q[WIDTH];
   assign bus.busy      = busy_r;
   assign bus.sel_err   = sel_err_r;
endmodule

// File: tb/tb_chime_selector.sv
// Directed bench for chime_selector: a 4-channel instance for the main scenarios
// and a 3-channel instance where an out-of-range select is representable.
module tb_chime_selector;
   localparam int W = 24;
`ifdef CHIME_SEL_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   localparam logic [W-1:0] C0 = 24'h000111;
   localparam logic [W-1:0] C1 = 24'h111000;
   localparam logic [W-1:0] C2 = 24'hABCDEF;
   localparam logic [W-1:0] C3 = 24'h333333;
   localparam logic [W-1:0] D0 = 24'h0A0A0A;
   localparam logic [W-1:0] D1 = 24'h0B0B0B;
   localparam logic [W-1:0] D2 = 24'h0C0C0C;
   localparam logic [W-1:0] H0 = 24'h123456;
   localparam logic [W-1:0] H1 = 24'h654321;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chime_selector_if #(.WIDTH(W), .N_CH(4)) bus4 ();
   chime_selector_if #(.WIDTH(W), .N_CH(3)) bus3 ();

   chime_selector #(.WIDTH(W), .N_CH(4), .DELAY(5), .MUTE_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );
   chime_selector #(.WIDTH(W), .N_CH(3), .DELAY(5), .MUTE_CYCLES(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   int checks = 0;
   int errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus4.sel       = '0;
      bus4.sel_valid = 1'b0;
      bus4.ch_data   = {C3, C2, C1, C0};
      bus3.sel       = '0;
      bus3.sel_valid = 1'b0;
      bus3.ch_data   = {D2, D1, D0};
      repeat (3) step();
      checks++; if (bus4.out !== 24'h0) begin errors++; $display("FAIL reset_out got %h exp 000000", bus4.out); end
      checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus4.out_valid); end
      checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus4.busy); end
      checks++; if (bus4.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", bus4.sel_err); end
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++;
         if (bus4.out_valid !== (k >= 5)) begin
            errors++; $display("FAIL reset_latency_valid cyc %0d got %b exp %b", k, bus4.out_valid, (k >= 5));
         end
         if (k >= 5) begin
            checks++; if (bus4.out !== C0) begin errors++; $display("FAIL reset_latency_out cyc %0d got %h exp %h", k, bus4.out, C0); end
            checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_latency_busy cyc %0d got %b exp 0", k, bus4.busy); end
         end
      end
   endtask

   task automatic test_switch();
      logic [W-1:0] exp;
      for (int k = 0; k <= 14; k++) begin
         bus4.sel       = 2'd2;
         bus4.sel_valid = (k == 0);
         step();
         bus4.sel_valid = 1'b0;
         exp = (k <= 4) ? C0 : (k <= 12) ? (HOLD ? C0 : '0) : C2;
         checks++; if (bus4.out !== exp) begin errors++; $display("FAIL switch_out k %0d got %h exp %h", k, bus4.out, exp); end
         checks++; if (bus4.busy !== (k <= 7)) begin errors++; $display("FAIL switch_busy k %0d got %b exp %b", k, bus4.busy, (k <= 7)); end
      end
   endtask

   task automatic test_restart();
      logic [W-1:0] exp;
      for (int k = 0; k <= 18; k++) begin
         bus4.sel       = (k == 0) ? 2'd1 : 2'd3;
         bus4.sel_valid = (k == 0) || (k == 4);
         step();
         bus4.sel_valid = 1'b0;
         exp = (k <= 4) ? C2 : (k <= 16) ? (HOLD ? C2 : '0) : C3;
         checks++; if (bus4.out !== exp) begin errors++; $display("FAIL restart_out k %0d got %h exp %h", k, bus4.out, exp); end
         checks++; if (bus4.busy !== (k <= 11)) begin errors++; $display("FAIL restart_busy k %0d got %b exp %b", k, bus4.busy, (k <= 11)); end
      end
   endtask

   task automatic test_same_select();
      for (int k = 0; k <= 8; k++) begin
         bus4.sel       = 2'd3;
         bus4.sel_valid = (k == 0);
         step();
         bus4.sel_valid = 1'b0;
         checks++; if (bus4.out !== C3) begin errors++; $display("FAIL same_out k %0d got %h exp %h", k, bus4.out, C3); end
         checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL same_busy k %0d got %b exp 0", k, bus4.busy); end
      end
      checks++; if (bus4.sel_err !== 1'b0) begin errors++; $display("FAIL same_sel_err got %b exp 0", bus4.sel_err); end
   endtask

   task automatic test_illegal();
      logic [W-1:0] exp;
      for (int k = 0; k <= 8; k++) begin
         bus3.sel       = 2'd3;
         bus3.sel_valid = (k == 0);
         step();
         bus3.sel_valid = 1'b0;
         checks++; if (bus3.sel_err !== 1'b1) begin errors++; $display("FAIL illegal_sel_err k %0d got %b exp 1", k, bus3.sel_err); end
         checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL illegal_busy k %0d got %b exp 0", k, bus3.busy); end
         checks++; if (bus3.out !== D0) begin errors++; $display("FAIL illegal_out k %0d got %h exp %h", k, bus3.out, D0); end
      end
      // A later legal switch still works and does not clear the sticky flag.
      for (int k = 0; k <= 13; k++) begin
         bus3.sel       = 2'd2;
         bus3.sel_valid = (k == 0);
         step();
         bus3.sel_valid = 1'b0;
         exp = (k <= 4) ? D0 : (k <= 12) ? (HOLD ? D0 : '0) : D2;
         checks++; if (bus3.out !== exp) begin errors++; $display("FAIL n3_switch_out k %0d got %h exp %h", k, bus3.out, exp); end
         checks++; if (bus3.sel_err !== 1'b1) begin errors++; $display("FAIL n3_sticky k %0d got %b exp 1", k, bus3.sel_err); end
      end
   endtask

   task automatic test_reset_mid_mute();
      bus4.sel       = 2'd1;
      bus4.sel_valid = 1'b1;
      step();
      bus4.sel_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      checks++; if (bus4.out !== 24'h0) begin errors++; $display("FAIL midrst_out got %h exp 000000", bus4.out); end
      checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus4.busy); end
      checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus4.out_valid); end
      checks++; if (bus3.sel_err !== 1'b0) begin errors++; $display("FAIL midrst_sel_err_clear got %b exp 0", bus3.sel_err); end
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         checks++;
         if (bus4.out_valid !== (k >= 5)) begin
            errors++; $display("FAIL midrst_latency_valid cyc %0d got %b exp %b", k, bus4.out_valid, (k >= 5));
         end
         checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL midrst_after_busy cyc %0d got %b exp 0", k, bus4.busy); end
         if (k >= 5) begin
            checks++; if (bus4.out !== C0) begin errors++; $display("FAIL midrst_after_out cyc %0d got %h exp %h", k, bus4.out, C0); end
         end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] exp;
      bus4.ch_data[0 +: W] = H0;
      bus4.ch_data[W +: W] = H1;
      repeat (6) step();
      for (int k = 0; k <= 14; k++) begin
         bus4.sel       = 2'd1;
         bus4.sel_valid = (k == 0);
         step();
         bus4.sel_valid = 1'b0;
         exp = (k <= 4) ? H0 : (k <= 12) ? (HOLD ? H0 : '0) : H1;
         checks++; if (bus4.out !== exp) begin errors++; $display("FAIL hold_out k %0d got %h exp %h", k, bus4.out, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_switch();
      test_restart();
      test_same_select();
      test_illegal();
      test_reset_mid_mute();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "bench did not complete");
   end
endmodule
